// File: rtl/err_log_pkg.sv
// Shared types and constants for the error-event logger: the log entry
// layout, the drop counter width and its saturating add.
package err_log_pkg;

    localparam int DROP_W     = 8;
    localparam int DROP_MAX   = (1 << DROP_W) - 1;

    // Entry fields are sized for the largest supported configuration;
    // narrower instances zero-fill the upper bits.
    localparam int SRC_MAX_W  = 8;
    localparam int CODE_MAX_W = 16;
    localparam int TS_MAX_W   = 32;

    typedef struct packed {
        logic [SRC_MAX_W-1:0]  src;
        logic [CODE_MAX_W-1:0] code;
        logic [TS_MAX_W-1:0]   ts;
    } log_entry_t;

    localparam int ENTRY_W = $bits(log_entry_t);

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input int unsigned n);
        int unsigned s;
        s = 32'(a) + n;
        if (s > DROP_MAX) begin
            s = DROP_MAX;
        end
        return DROP_W'(s);
    endfunction

endpackage

// File: rtl/err_log_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra MSB so
// full and empty are distinguished without a separate occupancy counter.
module err_log_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count = wptr_q - rptr_q;
    assign do_rd = rd_en && !empty;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign do_wr = wr_en && (!full || do_rd) && !clr;

    always_comb begin
        wptr_d = wptr_q + (AW+1)'(do_wr);
        rptr_d = rptr_q + (AW+1)'(do_rd);
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = empty ? '0 : mem[rptr_q[AW-1:0]];

endmodule

// File: rtl/err_log.sv
// Error-event logger: detects code changes on NUM_SRC sources, timestamps them
// and queues them in a FWFT log. Define ERR_LOG_CLEAR_EVT_EN to also log changes to code 0.
module err_log
    import err_log_pkg::*;
#(
    parameter int  NUM_SRC = 2,
    parameter int  CODE_W  = 4,
    parameter int  DEPTH   = 16,
    parameter int  TS_W    = 24,
    localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [NUM_SRC*CODE_W-1:0] src_err,
    input  logic                      clr,
    input  logic                      rd_en,
    output logic                      rd_vld,
    output logic [SRC_W-1:0]          rd_src,
    output logic [CODE_W-1:0]         rd_code,
    output logic [TS_W-1:0]           rd_ts,
    output logic [AW:0]               count,
    output logic                      overflow,
    output logic [DROP_W-1:0]         drop_cnt
);

`ifdef ERR_LOG_CLEAR_EVT_EN
    localparam bit CLR_EVT_EN = 1'b1;
`else
    localparam bit CLR_EVT_EN = 1'b0;
`endif

    logic [NUM_SRC*CODE_W-1:0] src_q, src_d;
    logic                      armed_q, armed_d;
    logic [TS_W-1:0]           ts_q, ts_d;
    logic                      overflow_q, overflow_d;
    logic [DROP_W-1:0]         drop_cnt_q, drop_cnt_d;

    logic [NUM_SRC-1:0]        pend_vld;
    logic [CODE_W-1:0]         pend_code [NUM_SRC];
    logic [TS_W-1:0]           pend_ts   [NUM_SRC];
    logic [NUM_SRC-1:0]        ovwr;

    logic                      has_sel;
    logic [SRC_W-1:0]          sel;
    logic                      fifo_full, fifo_empty;
    logic                      do_pop, wr_accept, wr_drop;
    int unsigned               lost_cnt;
    log_entry_t                wr_entry, head;
    logic [ENTRY_W-1:0]        fifo_rdata;

    // Fixed priority: the lowest pending source index wins the write port.
    always_comb begin
        has_sel = 1'b0;
        sel     = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend_vld[i]) begin
                has_sel = 1'b1;
                sel     = SRC_W'(i);
            end
        end
    end

    assign do_pop    = rd_en && !fifo_empty;
    assign wr_accept = has_sel && !clr && (!fifo_full || do_pop);
    assign wr_drop   = has_sel && !clr && fifo_full && !do_pop;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [CODE_W-1:0] cur, prev;
        logic              evt, taken;
        logic              slot_vld_q, slot_vld_d;
        logic [CODE_W-1:0] slot_code_q, slot_code_d;
        logic [TS_W-1:0]   slot_ts_q, slot_ts_d;

        assign cur   = src_err[gi*CODE_W +: CODE_W];
        assign prev  = src_q[gi*CODE_W +: CODE_W];
        assign taken = has_sel && (sel == SRC_W'(gi));
        // armed_q masks the first edge after reset, when src_q is not yet meaningful.
        assign evt   = armed_q && (cur != prev) && (CLR_EVT_EN || (cur != '0));
        // Only a slot that stays occupied through this edge loses its old event.
        assign ovwr[gi] = !clr && evt && slot_vld_q && !taken;

        always_comb begin
            slot_vld_d  = slot_vld_q;
            slot_code_d = slot_code_q;
            slot_ts_d   = slot_ts_q;
            if (clr) begin
                slot_vld_d = 1'b0;
            end else if (evt) begin
                slot_vld_d  = 1'b1;
                slot_code_d = cur;
                slot_ts_d   = ts_q;
            end else if (taken) begin
                slot_vld_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                slot_vld_q  <= 1'b0;
                slot_code_q <= '0;
                slot_ts_q   <= '0;
            end else begin
                slot_vld_q  <= slot_vld_d;
                slot_code_q <= slot_code_d;
                slot_ts_q   <= slot_ts_d;
            end
        end

        assign pend_vld[gi]  = slot_vld_q;
        assign pend_code[gi] = slot_code_q;
        assign pend_ts[gi]   = slot_ts_q;
    end

    always_comb begin
        lost_cnt = wr_drop ? 1 : 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            lost_cnt = lost_cnt + 32'(ovwr[i]);
        end
    end

    always_comb begin
        src_d      = src_err;
        armed_d    = 1'b1;
        ts_d       = ts_q + TS_W'(1);
        overflow_d = overflow_q | (lost_cnt != 0);
        drop_cnt_d = sat_add(drop_cnt_q, lost_cnt);
        if (clr) begin
            ts_d       = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            src_q      <= '0;
            armed_q    <= 1'b0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            src_q      <= src_d;
            armed_q    <= armed_d;
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        wr_entry                  = '0;
        wr_entry.src[SRC_W-1:0]   = sel;
        wr_entry.code[CODE_W-1:0] = pend_code[sel];
        wr_entry.ts[TS_W-1:0]     = pend_ts[sel];
    end

    err_log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .arst_n  (arst_n),
        .clr     (clr),
        .wr_en   (wr_accept),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (count)
    );

    assign head     = fifo_rdata;
    assign rd_vld   = !fifo_empty;
    assign rd_src   = head.src[SRC_W-1:0];
    assign rd_code  = head.code[CODE_W-1:0];
    assign rd_ts    = head.ts[TS_W-1:0];
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_err_log.sv
// Scoreboard bench for err_log: a cycle-level reference model pushes expected
// log entries; a negedge monitor pops and compares whenever the DUT pops.
module tb_err_log;

    localparam int NUM_SRC = 2;
    localparam int CODE_W  = 4;
    localparam int DEPTH   = 16;
    localparam int TS_W    = 24;
    localparam int SW      = NUM_SRC * CODE_W;

`ifdef ERR_LOG_CLEAR_EVT_EN
    localparam bit CLR_EVT = 1'b1;
`else
    localparam bit CLR_EVT = 1'b0;
`endif

    logic              clk     = 1'b0;
    logic              arst_n  = 1'b0;
    logic              clr     = 1'b0;
    logic              rd_en   = 1'b0;
    logic [SW-1:0]     src_err = '0;
    logic              rd_vld;
    logic [0:0]        rd_src;
    logic [CODE_W-1:0] rd_code;
    logic [TS_W-1:0]   rd_ts;
    logic [4:0]        count;
    logic              overflow;
    logic [7:0]        drop_cnt;

    err_log #(
        .NUM_SRC (NUM_SRC),
        .CODE_W  (CODE_W),
        .DEPTH   (DEPTH),
        .TS_W    (TS_W)
    ) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .src_err  (src_err),
        .clr      (clr),
        .rd_en    (rd_en),
        .rd_vld   (rd_vld),
        .rd_src   (rd_src),
        .rd_code  (rd_code),
        .rd_ts    (rd_ts),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     src;
        int     code;
        longint ts;
    } ent_t;

    ent_t   sb_q[$];
    int     m_prev [NUM_SRC];
    bit     m_armed;
    longint m_ts;
    bit     m_pv   [NUM_SRC];
    int     m_pc   [NUM_SRC];
    longint m_pt   [NUM_SRC];
    int     m_cnt;
    bit     m_ovf;
    int     m_drop;
    int     vectors     = 0;
    int     miscompares = 0;
    bit     done        = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int code_of(input int i);
        logic [SW-1:0] v;
        v = src_err >> (i * CODE_W);
        return int'(v[CODE_W-1:0]);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_SRC; i++) begin
            m_prev[i] = 0;
            m_pv[i]   = 1'b0;
            m_pc[i]   = 0;
            m_pt[i]   = 0;
        end
        m_armed = 1'b0;
        m_ts    = 0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_drop  = 0;
        sb_q.delete();
    endfunction

    // One clock edge of the logger's intended behaviour, from the current inputs.
    function automatic void model_step();
        int   lost;
        bit   popped;
        int   c;
        ent_t e;
        lost = 0;
        if (clr) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                m_pv[i]   = 1'b0;
                m_prev[i] = code_of(i);
            end
            m_cnt   = 0;
            m_ovf   = 1'b0;
            m_drop  = 0;
            m_ts    = 0;
            m_armed = 1'b1;
            sb_q.delete();
            return;
        end
        popped = rd_en && (m_cnt > 0);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (m_pv[i]) begin
                if (m_cnt < DEPTH || popped) begin
                    e.src  = i;
                    e.code = m_pc[i];
                    e.ts   = m_pt[i];
                    sb_q.push_back(e);
                    m_cnt++;
                end else begin
                    lost++;
                end
                m_pv[i] = 1'b0;
                break;
            end
        end
        if (popped) m_cnt--;
        for (int i = 0; i < NUM_SRC; i++) begin
            c = code_of(i);
            if (m_armed && c != m_prev[i] && (c != 0 || CLR_EVT)) begin
                if (m_pv[i]) lost++;
                m_pv[i] = 1'b1;
                m_pc[i] = c;
                m_pt[i] = m_ts;
            end
            m_prev[i] = c;
        end
        m_drop  = (m_drop + lost > 255) ? 255 : m_drop + lost;
        if (lost > 0) m_ovf = 1'b1;
        m_ts    = (m_ts + 1) % (longint'(1) << TS_W);
        m_armed = 1'b1;
    endfunction

    // Monitor: status every cycle; head entry checked whenever the DUT pops.
    always @(negedge clk) begin
        ent_t e;
        if (!done) begin
            chk("rd_vld", rd_vld, m_cnt != 0);
            chk("count", count, m_cnt);
            chk("overflow", overflow, m_ovf);
            chk("drop_cnt", drop_cnt, m_drop);
            if (!arst_n) begin
                chk("rst_rd_src", rd_src, 0);
                chk("rst_rd_code", rd_code, 0);
                chk("rst_rd_ts", rd_ts, 0);
            end
            if (rd_vld && rd_en) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pop_entry: got src=%0d code=%0d ts=%0d, want no entry",
                             rd_src, rd_code, rd_ts);
                end else begin
                    e = sb_q.pop_front();
                    chk("rd_src", rd_src, e.src);
                    chk("rd_code", rd_code, e.code);
                    chk("rd_ts", rd_ts, e.ts);
                    $display("pop src=%0d code=%0d ts=%0d", rd_src, rd_code, rd_ts);
                end
            end
        end
    end

    // Entered and left 3 time units after a rising edge.
    task automatic step(input logic [SW-1:0] s, input bit c, input bit r);
        src_err = s;
        clr     = c;
        rd_en   = r;
        @(posedge clk);
        model_step();
        #3;
    endtask

    task automatic idle(input int n, input bit r);
        repeat (n) step(src_err, 1'b0, r);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        clr    = 1'b0;
        rd_en  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        arst_n = 1'b1;
    endtask

    initial begin
        logic [SW-1:0] ns;
        bit            r;
        bit            c;
        model_reset();
        @(posedge clk);
        #3;
        arst_n = 1'b1;
        idle(6, 1'b0);

        // Single event, then pop it.
        step(8'h04, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(1, 1'b1);

        // Both sources in the same cycle: src 0 first, same timestamp.
        step(8'h73, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(3, 1'b1);

        // Twenty events with no reads, then pop alongside a new event.
        for (int i = 0; i < 10; i++) begin
            step((i % 2) ? 8'h65 : 8'h9A, 1'b0, 1'b0);
        end
        idle(4, 1'b0);
        step(8'h6C, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Back-to-back changes on src 0 while src 1 also changes.
        step(8'h12, 1'b0, 1'b0);
        step(8'h25, 1'b0, 1'b0);
        step(8'h16, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Long overload to push drop_cnt into saturation.
        for (int i = 0; i < 300; i++) begin
            step((i % 2) ? 8'h3B : 8'hC4, 1'b0, 1'b0);
        end
        idle(2, 1'b0);

        // Flush, with an event in the same cycle.
        step(8'h55, 1'b1, 1'b0);
        idle(3, 1'b0);
        idle(3, 1'b1);

        // 4 -> 0 on src 0.
        step(8'h54, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(8'h50, 1'b0, 1'b0);
        idle(4, 1'b1);

        // Reset in the middle of filling, with non-zero codes held.
        step(8'h31, 1'b0, 1'b0);
        step(8'h42, 1'b0, 1'b0);
        step(8'h53, 1'b0, 1'b0);
        do_reset();
        idle(3, 1'b0);
        idle(2, 1'b1);

        // Randomised traffic with alternating read pressure.
        for (int k = 0; k < 3000; k++) begin
            ns = src_err;
            for (int i = 0; i < NUM_SRC; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    ns[i*CODE_W +: CODE_W] = CODE_W'($urandom_range(0, 15));
                end
            end
            r = ((k / 150) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 99) == 0);
            step(ns, c, r);
            if (k == 1700) do_reset();
        end
        idle(40, 1'b1);

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
